// File: rtl/rs_eint.sv
// rs_eint: integer-execute reservation station. Holds dispatched uops,
// wakes sources on writeback, issues oldest-ready uop (registered).
//
// Ports:
//   clk, reset (async, active-high)
//   disp_valid_rs0 / disp_rs0 / disp_src_pdg_rs0 / disp_src_robid_rs0 : dispatch in
//   rs_stall_rs0 : RS full (registered state only)
//   wb_valid_ex / wb_robid_ex : writeback wakeup
//   ex_stall_rs1 : execute back-pressure
//   flush : synchronous clear of all entries
//   iss_valid_rs1 / iss_rs1 : registered issue to execute
package rs_eint_pkg;
  localparam int NUM_SOURCES = 2;
  localparam int ROB_ID_W = 6;

  typedef logic [ROB_ID_W-1:0] t_rob_id;

  typedef struct packed {
    logic [15:0] uinstr;
    t_rob_id     robid;
    logic [6:0]  pdst;
  } t_uinstr_disp;
endpackage

module rs_eint
  import rs_eint_pkg::*;
#(
  parameter  int NUM_ENTRIES = 8,
  localparam int IDX_W = $clog2(NUM_ENTRIES)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         disp_valid_rs0,
  input  t_uinstr_disp                 disp_rs0,
  input  logic [NUM_SOURCES-1:0]       disp_src_pdg_rs0,
  input  t_rob_id [NUM_SOURCES-1:0]    disp_src_robid_rs0,
  output logic                         rs_stall_rs0,
  input  logic                         wb_valid_ex,
  input  t_rob_id                      wb_robid_ex,
  input  logic                         ex_stall_rs1,
  input  logic                         flush,
  output logic                         iss_valid_rs1,
  output t_uinstr_disp                 iss_rs1
);

  logic [NUM_ENTRIES-1:0]                  valid;
  logic [NUM_ENTRIES-1:0][NUM_SOURCES-1:0] pdg;
  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] age;
  t_uinstr_disp                            uop   [NUM_ENTRIES];
  t_rob_id                                 srcid [NUM_ENTRIES][NUM_SOURCES];

  logic [NUM_ENTRIES-1:0] ready;
  logic [NUM_ENTRIES-1:0] sel_oh;
  logic [IDX_W-1:0]       sel_idx;
  logic [IDX_W-1:0]       free_idx;
  logic                   sel_fire;
  logic                   disp_fire;
  logic [NUM_SOURCES-1:0] disp_pdg;

  assign rs_stall_rs0 = &valid;
  assign disp_fire = disp_valid_rs0 & ~rs_stall_rs0 & ~flush;

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      ready[i] = valid[i] & ~|pdg[i];
    end
  end

  // Lowest-index free entry; an entry issuing this cycle is
  // still valid, so it cannot be reused until the next cycle.
  always_comb begin
    free_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) free_idx = IDX_W'(i);
    end
  end

  // Oldest ready: a ready entry loses if any other ready entry
  // is not younger than it.
  always_comb begin
    sel_oh = ready;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        if (j != i && ready[j] && !age[i][j]) sel_oh[i] = 1'b0;
      end
    end
  end

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (sel_oh[i]) sel_idx = IDX_W'(i);
    end
  end

  assign sel_fire = (|sel_oh) & ~ex_stall_rs1 & ~flush;

  // Same-cycle writeback bypass for dispatching sources.
  always_comb begin
    for (int s = 0; s < NUM_SOURCES; s++) begin
      disp_pdg[s] = disp_src_pdg_rs0[s] &
        ~(wb_valid_ex & (wb_robid_ex == disp_src_robid_rs0[s]));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid         <= '0;
      pdg           <= '0;
      age           <= '0;
      iss_valid_rs1 <= 1'b0;
      iss_rs1       <= '0;
    end else begin
      iss_valid_rs1 <= sel_fire;
      if (sel_fire) iss_rs1 <= uop[sel_idx];
      if (flush) begin
        valid <= '0;
        age   <= '0;
      end else begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
          for (int s = 0; s < NUM_SOURCES; s++) begin
            if (valid[i] && pdg[i][s] && wb_valid_ex &&
                srcid[i][s] == wb_robid_ex)
              pdg[i][s] <= 1'b0;
          end
        end
        if (sel_fire) valid[sel_idx] <= 1'b0;
        if (disp_fire) begin
          valid[free_idx] <= 1'b1;
          pdg[free_idx]   <= disp_pdg;
          for (int j = 0; j < NUM_ENTRIES; j++) begin
            age[free_idx][j] <= 1'b0;
            age[j][free_idx] <= (j != int'(free_idx));
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (disp_fire) begin
      uop[free_idx] <= disp_rs0;
      for (int s = 0; s < NUM_SOURCES; s++) begin
        srcid[free_idx][s] <= disp_src_robid_rs0[s];
      end
    end
  end

  a_no_disp_full: assert property (
    @(posedge clk) disable iff (reset)
    !(disp_valid_rs0 && rs_stall_rs0)
  );

endmodule

// File: tb/tb_rs_eint.sv
// tb_rs_eint: randomized + directed bench for rs_eint with an
// age-ordered queue model and an issue scoreboard.
module tb_rs_eint;
  import rs_eint_pkg::*;

  localparam int N = 8;

  logic                      clk = 0;
  logic                      reset = 1;
  logic                      disp_valid_rs0 = 0;
  t_uinstr_disp              disp_rs0 = '0;
  logic [NUM_SOURCES-1:0]    disp_src_pdg_rs0 = '0;
  t_rob_id [NUM_SOURCES-1:0] disp_src_robid_rs0 = '0;
  logic                      rs_stall_rs0;
  logic                      wb_valid_ex = 0;
  t_rob_id                   wb_robid_ex = '0;
  logic                      ex_stall_rs1 = 0;
  logic                      flush = 0;
  logic                      iss_valid_rs1;
  t_uinstr_disp              iss_rs1;

  rs_eint #(.NUM_ENTRIES(N)) dut (
    .clk(clk), .reset(reset),
    .disp_valid_rs0(disp_valid_rs0), .disp_rs0(disp_rs0),
    .disp_src_pdg_rs0(disp_src_pdg_rs0),
    .disp_src_robid_rs0(disp_src_robid_rs0),
    .rs_stall_rs0(rs_stall_rs0),
    .wb_valid_ex(wb_valid_ex), .wb_robid_ex(wb_robid_ex),
    .ex_stall_rs1(ex_stall_rs1), .flush(flush),
    .iss_valid_rs1(iss_valid_rs1), .iss_rs1(iss_rs1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    t_uinstr_disp u;
    logic [1:0]   pdg;
    t_rob_id [1:0] src;
  } ent_t;

  typedef struct packed {
    t_uinstr_disp u;
    int           cyc;
  } exp_t;

  ent_t mq[$];
  exp_t expq[$];
  int checks = 0;
  int failures = 0;
  int issues = 0;

  // Monitor: every issue must match the next expected uop and cycle.
  always @(negedge clk) begin
    if (!reset && iss_valid_rs1) begin
      exp_t e;
      issues++;
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_issue act=%h req=none cyc=%0d",
                 iss_rs1, cyc);
      end else begin
        e = expq.pop_front();
        if (iss_rs1 !== e.u || cyc != e.cyc) begin
          failures++;
          $display("FAIL issue act=%h@%0d req=%h@%0d",
                   iss_rs1, cyc, e.u, e.cyc);
        end
      end
    end
  end

  function automatic t_uinstr_disp mk(input int rid);
    t_uinstr_disp u;
    u.uinstr = 16'($urandom);
    u.robid  = t_rob_id'(rid);
    u.pdst   = 7'($urandom);
    return u;
  endfunction

  task automatic step(input logic dv, input t_uinstr_disp u,
                      input logic [1:0] pd, input t_rob_id s0,
                      input t_rob_id s1, input logic wbv,
                      input t_rob_id wbr, input logic exs,
                      input logic fl);
    int n0;
    int hit;
    ent_t e;
    @(negedge clk);
    #1;
    n0 = mq.size();
    checks++;
    if (rs_stall_rs0 !== (n0 == N)) begin
      failures++;
      $display("FAIL stall act=%b req=%b cyc=%0d",
               rs_stall_rs0, (n0 == N), cyc);
    end
    if (n0 == N) dv = 1'b0;
    disp_valid_rs0        = dv;
    disp_rs0              = u;
    disp_src_pdg_rs0      = pd;
    disp_src_robid_rs0[0] = s0;
    disp_src_robid_rs0[1] = s1;
    wb_valid_ex           = wbv;
    wb_robid_ex           = wbr;
    ex_stall_rs1          = exs;
    flush                 = fl;
    // Issue: first (oldest) entry with nothing pending.
    if (!exs && !fl) begin
      hit = -1;
      foreach (mq[k]) if (hit < 0 && mq[k].pdg == 2'b00) hit = k;
      if (hit >= 0) begin
        expq.push_back('{u: mq[hit].u, cyc: cyc + 1});
        mq.delete(hit);
      end
    end
    foreach (mq[k])
      for (int s = 0; s < 2; s++)
        if (wbv && mq[k].src[s] == wbr) mq[k].pdg[s] = 1'b0;
    if (fl) begin
      mq.delete();
    end else if (dv) begin
      e.u = u;
      e.src[0] = s0;
      e.src[1] = s1;
      e.pdg[0] = pd[0] && !(wbv && wbr == s0);
      e.pdg[1] = pd[1] && !(wbv && wbr == s1);
      mq.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, '0, 2'b00, '0, '0, 0, '0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1;
    disp_valid_rs0 = 0;
    wb_valid_ex = 0;
    ex_stall_rs1 = 0;
    flush = 0;
    mq.delete();
    expq.delete();
    @(negedge clk);
    checks += 3;
    if (iss_valid_rs1 !== 1'b0) begin
      failures++;
      $display("FAIL rst_iss_valid act=%b req=0", iss_valid_rs1);
    end
    if (iss_rs1 !== '0) begin
      failures++;
      $display("FAIL rst_iss_rs1 act=%h req=0", iss_rs1);
    end
    if (rs_stall_rs0 !== 1'b0) begin
      failures++;
      $display("FAIL rst_stall act=%b req=0", rs_stall_rs0);
    end
    #1;
    reset = 0;
  endtask

  task automatic rand_run(input int n);
    for (int i = 0; i < n; i++) begin
      logic [1:0] pd;
      pd[0] = ($urandom_range(0, 2) == 0);
      pd[1] = ($urandom_range(0, 2) == 0);
      step($urandom_range(0, 2) != 0, mk($urandom_range(0, 63)), pd,
           t_rob_id'($urandom_range(0, 15)),
           t_rob_id'($urandom_range(0, 15)),
           $urandom_range(0, 1) == 1,
           t_rob_id'($urandom_range(0, 15)),
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 63) == 0);
    end
  endtask

  task automatic drain();
    for (int r = 0; r < 64; r++)
      step(0, '0, 2'b00, '0, '0, 1, t_rob_id'(r), 0, 0);
    idle(4);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    do_reset();

    // 1: ready dispatch issues two cycles later
    step(1, mk(3), 2'b00, '0, '0, 0, '0, 0, 0);
    idle(4);

    // 2: pending source woken by writeback
    step(1, mk(5), 2'b01, 6'h2, '0, 0, '0, 0, 0);
    idle(3);
    step(0, '0, 2'b00, '0, '0, 1, 6'h2, 0, 0);
    idle(4);

    // 3: fill, stall, one wakeup frees an entry
    for (int i = 0; i < N; i++)
      step(1, mk(16 + i), 2'b01, t_rob_id'(32 + i), '0, 0, '0, 0, 0);
    step(1, mk(40), 2'b00, '0, '0, 0, '0, 0, 0);
    step(0, '0, 2'b00, '0, '0, 1, 6'd35, 0, 0);
    idle(3);
    drain();

    // 4: held by ex_stall, then back-to-back in age order
    step(1, mk(7), 2'b00, '0, '0, 0, '0, 1, 0);
    step(1, mk(8), 2'b00, '0, '0, 0, '0, 1, 0);
    step(1, mk(9), 2'b00, '0, '0, 0, '0, 1, 0);
    step(0, '0, 2'b00, '0, '0, 0, '0, 1, 0);
    step(0, '0, 2'b00, '0, '0, 0, '0, 1, 0);
    idle(5);

    // 5: same-cycle writeback bypass
    step(1, mk(11), 2'b10, '0, 6'hA, 1, 6'hA, 0, 0);
    idle(4);

    // 6: flush with 4 valid entries, then normal dispatch
    for (int i = 0; i < 4; i++)
      step(1, mk(20 + i), 2'b11, 6'h30, 6'h31, 0, '0, 0, 0);
    step(1, mk(24), 2'b00, '0, '0, 0, '0, 0, 1);
    step(1, mk(25), 2'b00, '0, '0, 1, 6'h30, 0, 0);
    idle(4);

    rand_run(1500);
    drain();
    rand_run(200);
    do_reset();
    rand_run(1500);
    drain();

    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL missing_issues act=%0d req=0", expq.size());
    end
    checks++;
    if (issues < 20) begin
      failures++;
      $display("FAIL issue_count act=%0d req=>=20", issues);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
